// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the pipelined immediate generator.
// Optional CSR-immediate decode is enabled by defining IMM_GEN_CSR_EN.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Decode-side bundle: instruction in, immediate/type/illegal out, valid/ready
// handshakes on both sides plus the mispredict flush.
interface imm_gen_pipe_if
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst_code;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] Imm_out;
  imm_type_e       imm_type;
  logic            illegal;

  modport master (
    output flush, in_valid, inst_code, out_ready,
    input  in_ready, out_valid, Imm_out, imm_type, illegal
  );

  modport slave (
    input  flush, in_valid, inst_code, out_ready,
    output in_ready, out_valid, Imm_out, imm_type, illegal
  );
endinterface

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RV32 opcode decode to {immediate, format tag, illegal}.
// With IMM_GEN_CSR_EN defined, CSR*I instructions yield the zero-extended uimm.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]            inst_i,
  output logic signed [XLEN-1:0] imm_o,
  output imm_type_e              type_o,
  output logic                   illegal_o
);

  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic signed [XLEN-1:0] zext5(input logic [4:0] v);
    logic signed [XLEN-1:0] r;
    r      = '0;
    r[4:0] = v;
    return r;
  endfunction

  logic s;
  assign s = inst_i[31];

  always_comb begin
    imm_o     = '0;
    type_o    = IMM_NONE;
    illegal_o = 1'b0;
    case (inst_i[6:0])
      OP_LOAD, OP_IMM, OP_JALR: begin
        type_o = IMM_I;
        imm_o  = sext32({{20{s}}, inst_i[31:20]});
      end
      OP_STORE: begin
        type_o = IMM_S;
        imm_o  = sext32({{20{s}}, inst_i[31:25], inst_i[11:7]});
      end
      OP_BRANCH: begin
        type_o = IMM_B;
        imm_o  = sext32({{19{s}}, s, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0});
      end
      OP_LUI, OP_AUIPC: begin
        type_o = IMM_U;
        imm_o  = sext32({inst_i[31:12], 12'b0});
      end
      OP_JAL: begin
        type_o = IMM_J;
        imm_o  = sext32({{11{s}}, s, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0});
      end
      OP_REG: begin
        type_o = IMM_NONE;
      end
      OP_SYSTEM: begin
`ifdef IMM_GEN_CSR_EN
        // funct3[2] selects the immediate CSR forms; the rest carry no immediate
        if (inst_i[14]) begin
          type_o = IMM_Z;
          imm_o  = zext5(inst_i[19:15]);
        end
`else
        illegal_o = 1'b1;
`endif
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// STAGES-deep elastic pipeline around imm_decode with flush and backpressure.
// Optional CSR-immediate decode (IMM_GEN_CSR_EN) lives in imm_decode.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input logic           clk,
  input logic           reset,
  imm_gen_pipe_if.slave bus
);

  logic signed [XLEN-1:0] dec_imm;
  imm_type_e              dec_type;
  logic                   dec_ill;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst_i    (bus.inst_code),
    .imm_o     (dec_imm),
    .type_o    (dec_type),
    .illegal_o (dec_ill)
  );

  logic [STAGES-1:0]      ld;
  logic [STAGES-1:0]      vld_q, vld_d;
  logic signed [XLEN-1:0] imm_q  [STAGES];
  logic signed [XLEN-1:0] imm_d  [STAGES];
  imm_type_e              type_q [STAGES];
  imm_type_e              type_d [STAGES];
  logic                   ill_q  [STAGES];
  logic                   ill_d  [STAGES];

  // A stage may load when the consumer drains, or some stage at/after it is
  // empty: that lets bubbles collapse under a stalled output.
  always_comb begin
    logic all_full;
    all_full = 1'b1;
    ld       = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      all_full = all_full & vld_q[k];
      ld[k]    = bus.out_ready | ~all_full;
    end
  end

  always_comb begin
    vld_d  = vld_q;
    imm_d  = imm_q;
    type_d = type_q;
    ill_d  = ill_q;
    for (int k = 0; k < STAGES; k++) begin
      if (ld[k]) begin
        if (k == 0) begin
          vld_d[k]  = bus.in_valid;
          imm_d[k]  = dec_imm;
          type_d[k] = dec_type;
          ill_d[k]  = dec_ill;
        end else begin
          vld_d[k]  = vld_q[(k == 0) ? 0 : k - 1];
          imm_d[k]  = imm_q[(k == 0) ? 0 : k - 1];
          type_d[k] = type_q[(k == 0) ? 0 : k - 1];
          ill_d[k]  = ill_q[(k == 0) ? 0 : k - 1];
        end
      end
    end
    if (bus.flush) vld_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      imm_q  <= '{default: '0};
      type_q <= '{default: IMM_NONE};
      ill_q  <= '{default: 1'b0};
    end else begin
      vld_q  <= vld_d;
      imm_q  <= imm_d;
      type_q <= type_d;
      ill_q  <= ill_d;
    end
  end

  // Flush discards whatever is offered, so accepting it is always safe.
  assign bus.in_ready  = ld[0] | bus.flush;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.Imm_out   = imm_q[STAGES-1];
  assign bus.imm_type  = type_q[STAGES-1];
  assign bus.illegal   = ill_q[STAGES-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: a 1-stage XLEN=32 instance and a 3-stage XLEN=64 instance.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32)) ifa ();
  imm_gen_pipe_if #(.XLEN(64)) ifb ();

  imm_gen_pipe #(.XLEN(32), .STAGES(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  imm_gen_pipe #(.XLEN(64), .STAGES(3)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

`ifdef IMM_GEN_CSR_EN
  localparam logic [31:0] CSRI_IMM = 32'd15;
  localparam imm_type_e   CSRI_T   = IMM_Z;
  localparam logic        CSRI_ILL = 1'b0;
  localparam logic        CSRW_ILL = 1'b0;
`else
  localparam logic [31:0] CSRI_IMM = 32'd0;
  localparam imm_type_e   CSRI_T   = IMM_NONE;
  localparam logic        CSRI_ILL = 1'b1;
  localparam logic        CSRW_ILL = 1'b1;
`endif

  localparam int NV = 13;
  logic [31:0] v_inst [NV] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'h800000EF,
                               32'h800000B7, 32'h12345017, 32'h80002083, 32'h00500013,
                               32'h00000033, 32'h0000007F, 32'h0000707F, 32'h0007D073,
                               32'h00001073};
  logic [31:0] v_imm  [NV] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFF00000,
                               32'h80000000, 32'h12345000, 32'hFFFFF800, 32'h00000005,
                               32'h0, 32'h0, 32'h0, CSRI_IMM, 32'h0};
  imm_type_e   v_type [NV] = '{IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_U, IMM_I, IMM_I,
                               IMM_NONE, IMM_NONE, IMM_NONE, CSRI_T, IMM_NONE};
  logic        v_ill  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b1, 1'b1, CSRI_ILL, CSRW_ILL};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi_k(input int k);
    return {k[11:0], 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int sent, got;
    logic fire_in, fire_out;

    ifa.flush = 1'b0; ifa.in_valid = 1'b0; ifa.inst_code = '0; ifa.out_ready = 1'b1;
    ifb.flush = 1'b0; ifb.in_valid = 1'b0; ifb.inst_code = '0; ifb.out_ready = 1'b1;

    // reset values
    #1 reset = 1'b1;
    #1;
    chk("rst.a.valid", 64'(ifa.out_valid), 64'd0);
    chk("rst.a.imm",   64'(ifa.Imm_out),   64'd0);
    chk("rst.a.type",  64'(ifa.imm_type),  64'(IMM_NONE));
    chk("rst.a.ill",   64'(ifa.illegal),   64'd0);
    chk("rst.b.valid", 64'(ifb.out_valid), 64'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst.a.in_ready", 64'(ifa.in_ready), 64'd1);
    chk("rst.b.in_ready", 64'(ifb.in_ready), 64'd1);

    // 1-stage: back-to-back decode table, one result per cycle
    ifa.in_valid = 1'b1;
    for (int i = 0; i < NV; i++) begin
      ifa.inst_code = v_inst[i];
      #1 chk($sformatf("A%0d.in_ready", i), 64'(ifa.in_ready), 64'd1);
      tick();
      chk($sformatf("A%0d.valid", i), 64'(ifa.out_valid), 64'd1);
      chk($sformatf("A%0d.imm", i),   64'(ifa.Imm_out),   64'(v_imm[i]));
      chk($sformatf("A%0d.type", i),  64'(ifa.imm_type),  64'(v_type[i]));
      chk($sformatf("A%0d.ill", i),   64'(ifa.illegal),   64'(v_ill[i]));
    end
    ifa.in_valid = 1'b0;
    tick();
    chk("A.drain.valid", 64'(ifa.out_valid), 64'd0);

    // 1-stage: stall, then async reset in the middle of the stall
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.inst_code = 32'hFE112E23;
    tick();
    chk("A.stall.valid", 64'(ifa.out_valid), 64'd1);
    chk("A.stall.imm",   64'(ifa.Imm_out),   64'hFFFFFFFC);
    ifa.inst_code = 32'hFFF00093;
    #1 chk("A.stall.in_ready", 64'(ifa.in_ready), 64'd0);
    tick();
    chk("A.hold.valid", 64'(ifa.out_valid), 64'd1);
    chk("A.hold.imm",   64'(ifa.Imm_out),   64'hFFFFFFFC);
    chk("A.hold.type",  64'(ifa.imm_type),  64'(IMM_S));
    #2 reset = 1'b1;
    #1;
    chk("A.arst.valid", 64'(ifa.out_valid), 64'd0);
    chk("A.arst.imm",   64'(ifa.Imm_out),   64'd0);
    chk("A.arst.type",  64'(ifa.imm_type),  64'(IMM_NONE));
    chk("A.arst.ill",   64'(ifa.illegal),   64'd0);
    tick();
    ifa.in_valid = 1'b0;
    reset = 1'b0;
    #1 chk("A.arst.in_ready", 64'(ifa.in_ready), 64'd1);
    ifa.out_ready = 1'b1;
    tick();
    chk("A.arst.nodrop", 64'(ifa.out_valid), 64'd0);

    // 3-stage, XLEN=64: latency and 64-bit sign extension
    ifb.in_valid  = 1'b1;
    ifb.inst_code = 32'hFFF00093;
    tick();
    ifb.inst_code = 32'h800000B7;
    chk("B.lat1.valid", 64'(ifb.out_valid), 64'd0);
    tick();
    ifb.in_valid = 1'b0;
    chk("B.lat2.valid", 64'(ifb.out_valid), 64'd0);
    tick();
    chk("B.lat3.valid", 64'(ifb.out_valid), 64'd1);
    chk("B.addi.imm",   64'(ifb.Imm_out),   64'hFFFF_FFFF_FFFF_FFFF);
    chk("B.addi.type",  64'(ifb.imm_type),  64'(IMM_I));
    tick();
    chk("B.lui.valid", 64'(ifb.out_valid), 64'd1);
    chk("B.lui.imm",   64'(ifb.Imm_out),   64'hFFFF_FFFF_8000_0000);
    chk("B.lui.type",  64'(ifb.imm_type),  64'(IMM_U));
    tick();
    chk("B.lat.empty", 64'(ifb.out_valid), 64'd0);

    // 3-stage: 5-cycle output stall with continuous input, then release
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      ifb.out_ready = (c >= 5);
      ifb.in_valid  = (sent < 8);
      ifb.inst_code = addi_k(sent + 1);
      #1;
      fire_in  = ifb.in_valid && ifb.in_ready;
      fire_out = ifb.out_valid && ifb.out_ready;
      if (c == 3 || c == 4) begin
        chk($sformatf("B.stall%0d.in_ready", c), 64'(ifb.in_ready), 64'd0);
        chk($sformatf("B.stall%0d.accepts", c),  64'(sent),         64'd3);
        chk($sformatf("B.stall%0d.hold", c),     64'(ifb.Imm_out),  64'd1);
      end
      if (fire_out) begin
        chk($sformatf("B.order%0d.imm", got), 64'(ifb.Imm_out), 64'(got + 1));
        got++;
      end
      tick();
      if (fire_in) sent++;
    end
    ifb.in_valid = 1'b0;
    chk("B.stall.sent", 64'(sent), 64'd8);
    chk("B.stall.got",  64'(got),  64'd8);
    chk("B.stall.nodup", 64'(ifb.out_valid), 64'd0);

    // 3-stage: flush with two entries in flight and a word offered alongside
    ifb.out_ready = 1'b1;
    ifb.in_valid  = 1'b1;
    ifb.inst_code = addi_k(33);
    tick();
    ifb.inst_code = addi_k(34);
    tick();
    ifb.flush     = 1'b1;
    ifb.inst_code = addi_k(12'h555);
    #1 chk("B.flush.in_ready", 64'(ifb.in_ready), 64'd1);
    tick();
    ifb.flush    = 1'b0;
    ifb.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("B.flush%0d.valid", c), 64'(ifb.out_valid), 64'd0);
      tick();
    end
    ifb.in_valid  = 1'b1;
    ifb.inst_code = 32'hFE112E23;
    tick();
    ifb.in_valid = 1'b0;
    tick();
    chk("B.post.early", 64'(ifb.out_valid), 64'd0);
    tick();
    chk("B.post.valid", 64'(ifb.out_valid), 64'd1);
    chk("B.post.imm",   64'(ifb.Imm_out),   64'hFFFF_FFFF_FFFF_FFFC);
    chk("B.post.type",  64'(ifb.imm_type),  64'(IMM_S));
    chk("B.post.ill",   64'(ifb.illegal),   64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
